// File: rtl/fixed_point_pkg.sv
// Shared Q2.14 fixed-point constants, saturation limits and the state
// encoding used by the sequential arithmetic blocks.
package fixed_point_pkg;

   localparam int WIDTH = 16;
   localparam int FRAC  = 14;
   // Number of quotient bits produced; derived from WIDTH and FRAC.
   localparam int ITER  = WIDTH + FRAC;

   localparam logic [WIDTH-1:0] Q_ONE = 16'h4000;
   localparam logic [WIDTH-1:0] Q_MAX = 16'h7FFF;
   localparam logic [WIDTH-1:0] Q_MIN = 16'h8000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Unsigned magnitude of a two's complement value; -32768 maps to 0x8000.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
   endfunction

endpackage

// File: rtl/fixed_width_udiv_core.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// The dividend is loaded into the quotient shift register and shifted out
// into the partial remainder while quotient bits shift in at the bottom.
module fixed_width_udiv_core
   import fixed_point_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [ITER-1:0]  dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [ITER-1:0]  quotient,
   output logic             done
);

   localparam int CW = $clog2(ITER);

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic [ITER-1:0]  quo;
   logic [CW-1:0]    cnt;
   logic             busy;

   logic [WIDTH:0]   partial;
   logic             ge;
   logic [WIDTH-1:0] rem_next;

   // Trial subtraction for the current step. When ge holds, the difference is
   // below the divisor, so the low WIDTH bits of the modular result are exact.
   // With a zero divisor the remainder is meaningless; the top level overrides it.
   always_comb begin
      partial  = {rem, quo[ITER-1]};
      ge       = (partial >= {1'b0, dvs});
      rem_next = ge ? (partial[WIDTH-1:0] - dvs) : partial[WIDTH-1:0];
   end

   // Load on start, then one restoring step per cycle; done stays set until next start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem  <= '0;
         dvs  <= '0;
         quo  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         rem  <= '0;
         dvs  <= divisor;
         quo  <= dividend;
         cnt  <= '0;
         busy <= 1'b1;
         done <= 1'b0;
      end else if (busy) begin
         rem <= rem_next;
         quo <= {quo[ITER-2:0], ge};
         cnt <= cnt + CW'(1);
         if (cnt == CW'(ITER-1)) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

   assign quotient = quo;

endmodule

// File: rtl/fixed_width_divide_16bits_seq.sv
// Sequential signed Q2.14 divider: c = (a << FRAC) / b, truncating toward
// zero, saturating to the Q2.14 range, with valid/ready on both sides.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | in_ready high; a request captures magnitudes, sign and b==0
// CALC    | unsigned core runs ITER restoring steps; leave when core done
// FIX     | apply sign, saturation and divide-by-zero override; register
// DONE    | out_valid high, outputs held until out_ready
module fixed_width_divide_16bits_seq
   import fixed_point_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic             ovf,
   output logic             div_zero
);

   localparam logic [ITER-1:0] POS_LIM = ITER'(Q_MAX);
   localparam logic [ITER-1:0] NEG_LIM = ITER'(Q_MIN);

   logic [1:0]       state;
   logic             neg;
   logic             a_neg;
   logic             dz;
   logic             start;
   logic [ITER-1:0]  dividend;
   logic [ITER-1:0]  quotient;
   logic             core_done;
   logic [WIDTH-1:0] sat_c;
   logic             sat_ovf;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign start     = in_ready && in_valid;
   assign dividend  = {magnitude(a), {FRAC{1'b0}}};

   // The core latches the operand magnitudes on the accepting edge.
   fixed_width_udiv_core u_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .dividend (dividend),
      .divisor  (magnitude(b)),
      .quotient (quotient),
      .done     (core_done)
   );

   // Signed result from the unsigned quotient; -32768 exactly is representable.
   always_comb begin
      sat_c   = Q_MAX;
      sat_ovf = 1'b0;
      if (dz) begin
         sat_c = a_neg ? Q_MIN : Q_MAX;
      end else if (neg) begin
         if (quotient > NEG_LIM) begin
            sat_c   = Q_MIN;
            sat_ovf = 1'b1;
         end else begin
            sat_c = ~quotient[WIDTH-1:0] + WIDTH'(1);
         end
      end else begin
         if (quotient > POS_LIM) begin
            sat_c   = Q_MAX;
            sat_ovf = 1'b1;
         end else begin
            sat_c = quotient[WIDTH-1:0];
         end
      end
   end

   // Control FSM plus registered result; outputs hold their last value after DONE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         neg      <= 1'b0;
         a_neg    <= 1'b0;
         dz       <= 1'b0;
         c        <= '0;
         ovf      <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                  a_neg <= a[WIDTH-1];
                  dz    <= (b == '0);
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (core_done) state <= ST_FIX;
            end
            ST_FIX: begin
               c        <= sat_c;
               ovf      <= sat_ovf;
               div_zero <= dz;
               state    <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
